// File: rtl/mean_unit_if.sv
// Interface bundling the data-path signals of one mean_unit channel.
//   in_valid  : sample the inputs and compute at the next rising edge
//   x[i]      : binary activation X_i (bit i gates weight i)
//   wm[i]     : signed 20-bit weight Wm_i
//   b_mean    : signed 20-bit bias, always added
//   c_out     : registered, saturated signed 20-bit result
//   out_valid : high for one cycle when c_out holds a new result
// The master drives the stimulus; the slave (mean_unit) returns the result.
interface mean_unit_if;
  logic                in_valid;
  logic        [8:0]   x;
  logic signed [19:0]  wm [9];
  logic signed [19:0]  b_mean;
  logic signed [19:0]  c_out;
  logic                out_valid;

  modport master (
    output in_valid, x, wm, b_mean,
    input  c_out, out_valid
  );

  modport slave (
    input  in_valid, x, wm, b_mean,
    output c_out, out_valid
  );
endinterface

// File: rtl/mean_unit.sv
// mean_unit: signed weighted-sum neuron.
// Each binary activation x[i] gates its signed 20-bit weight wm[i]; the gated
// weights and the bias b_mean are summed in a 24-bit accumulator, saturated to
// 20 bits and registered. One result per in_valid cycle, latency one cycle.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (clears c_out and out_valid)
//   bus : mean_unit_if.slave (in_valid, x, wm, b_mean in; c_out, out_valid out)
module mean_unit (
  input  logic            clk,
  input  logic            rst,
  mean_unit_if.slave      bus
);

  // 24 bits hold the sum of ten 20-bit signed operands without overflow.
  localparam logic signed [23:0] SAT_MAX = 24'sd524287;
  localparam logic signed [23:0] SAT_MIN = -24'sd524288;

  logic signed [23:0] sum;
  logic signed [19:0] sat_sum;
  logic signed [19:0] c_out_d,     c_out_q;
  logic               out_valid_d, out_valid_q;

  // Gated-weight accumulation: an activation of 1 selects the weight, so no
  // multiplier is needed. Operands are sign-extended explicitly.
  always_comb begin
    sum = {{4{bus.b_mean[19]}}, bus.b_mean};
    for (int i = 0; i < 9; i++) begin
      if (bus.x[i]) begin
        sum = sum + {{4{bus.wm[i][19]}}, bus.wm[i]};
      end
    end
  end

  always_comb begin
    if (sum > SAT_MAX) begin
      sat_sum = 20'sh7FFFF;
    end else if (sum < SAT_MIN) begin
      sat_sum = -20'sh80000;
    end else begin
      sat_sum = sum[19:0];
    end
  end

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    c_out_d     = c_out_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      c_out_d     = sat_sum;
      out_valid_d = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.c_out     = c_out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mean_unit.sv
// Self-checking bench for mean_unit: directed vectors with known results,
// saturation, zero-activation, hold and reset cases, plus random vectors
// checked against an integer reference model through a scoreboard queue.
module tb_mean_unit;

  typedef logic signed [19:0] w_arr_t [9];

  typedef struct {
    string       tag;
    logic [19:0] exp;
  } sb_entry_t;

  logic clk;
  logic rst;
  int   assertions_evaluated;
  int   failures;
  logic [19:0] last_exp;
  sb_entry_t   sb [$];

  mean_unit_if bus ();

  mean_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    assertions_evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, then clamp to the 20-bit signed range.
  function automatic logic [19:0] model(input logic [8:0] x, input w_arr_t w,
                                        input logic signed [19:0] b);
    int s;
    s = int'(b);
    for (int i = 0; i < 9; i++) if (x[i]) s += int'(w[i]);
    if (s > 524287)       return 20'h7FFFF;
    else if (s < -524288) return 20'h80000;
    else                  return s[19:0];
  endfunction

  task automatic set_inputs(input logic [8:0] x, input w_arr_t w, input logic [19:0] b);
    bus.x      = x;
    bus.wm     = w;
    bus.b_mean = b;
  endtask

  // Drive one valid sample and queue its expected result.
  task automatic apply(input string tag, input logic [8:0] x, input w_arr_t w,
                       input logic [19:0] b, input logic [19:0] exp);
    sb_entry_t e;
    set_inputs(x, w, b);
    bus.in_valid = 1'b1;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    last_exp = exp;
    @(negedge clk);
  endtask

  function automatic w_arr_t rand_w();
    w_arr_t w;
    for (int i = 0; i < 9; i++) w[i] = 20'($urandom);
    return w;
  endfunction

  // Hold: idle cycle with every input changed; output must not move.
  task automatic hold_check(input string tag);
    set_inputs(~bus.x, rand_w(), 20'($urandom));
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_c_out"}, bus.c_out, last_exp);
    check({tag, "_out_valid"}, 20'(bus.out_valid), 20'd0);
  endtask

  // Monitor: every out_valid pulse must match the oldest queued expectation.
  always @(posedge clk) begin
    sb_entry_t e;
    #1;
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_result", bus.c_out, 20'hxxxxx);
      end else begin
        e = sb.pop_front();
        check(e.tag, bus.c_out, e.exp);
      end
    end
  end

  w_arr_t w_ch1, w_ch2, w_max, w_min;

  initial begin
    logic [8:0]  rx;
    w_arr_t      rw;
    logic [19:0] rb;

    assertions_evaluated = 0;
    failures             = 0;
    last_exp             = '0;

    w_ch1 = '{20'hFFFF3, 20'hFFFA5, 20'hFFFF3, 20'hFFFD9, 20'h0004E,
              20'hFFF8B, 20'hFE82E, 20'h09BF7, 20'h03109};
    w_ch2 = '{20'hFFF91, 20'h0007C, 20'hFFF98, 20'h0006F, 20'hFFF49,
              20'h00075, 20'h03E90, 20'hFC35E, 20'h050F2};
    for (int i = 0; i < 9; i++) begin
      w_max[i] = 20'h7FFFF;
      w_min[i] = 20'h80000;
    end

    // Reset with a simultaneous valid sample: the sample is discarded.
    rst = 1'b1;
    bus.in_valid = 1'b1;
    set_inputs(9'b111101111, w_ch1, 20'hFA2D8);
    @(negedge clk);
    check("reset_c_out", bus.c_out, 20'h00000);
    check("reset_out_valid", 20'(bus.out_valid), 20'd0);
    rst = 1'b0;

    // Directed vectors, back-to-back. x bit i is X_i.
    apply("ch1_a", 9'b111101111, w_ch1, 20'hFA2D8, 20'h056F5);
    apply("ch1_b", 9'b101010101, w_ch1, 20'hFA2D8, 20'hFBC43);
    apply("ch2_a", 9'b111101111, w_ch2, 20'hF9C13, 20'hFEF7C);
    apply("ch2_b", 9'b101010101, w_ch2, 20'hF9C13, 20'h02A07);
    apply("sat_max", 9'h1FF, w_max, 20'h7FFFF, 20'h7FFFF);
    apply("sat_min", 9'h1FF, w_min, 20'h80000, 20'h80000);
    apply("all_zero_x", 9'h000, rand_w(), 20'h12345, 20'h12345);
    hold_check("hold1");

    // Random vectors against the reference model.
    for (int k = 0; k < 8; k++) begin
      rx = 9'($urandom);
      rw = rand_w();
      rb = 20'($urandom);
      apply($sformatf("rand_%0d", k), rx, rw, rb, model(rx, rw, rb));
    end
    hold_check("hold2");

    // Reset mid-stream with a valid sample: cleared and nothing emitted.
    rst = 1'b1;
    bus.in_valid = 1'b1;
    set_inputs(9'h1FF, w_max, 20'h7FFFF);
    @(negedge clk);
    check("reset2_c_out", bus.c_out, 20'h00000);
    check("reset2_out_valid", 20'(bus.out_valid), 20'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 20'(sb.size()), 20'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertions_evaluated, failures);
    $finish;
  end

endmodule
